// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single Dcache port between load misses coming out of the LSQ and
//   retired stores from the ROB. Retired stores wait in a small FIFO store
//   buffer and drain whenever the port is not taken by a load. Loads normally
//   win, but a starvation counter, a watermark-driven DRAIN mode and an
//   explicit FLUSH sequence make sure stores always make progress.
//
//   Ports
//     clock, reset            single clock; reset is asynchronous, active-low
//     lsq_ld_*                load request (address, physical/arch dest tags)
//     ld_accept               load taken this cycle (by the Dcache or forwarded)
//     rob_st_*                retired store to enqueue (address, data)
//     st_buf_full/count       store-buffer occupancy; rob stalls stores when full
//     flush_req/flush_done    drain every store; done is a one-cycle pulse
//     Dcache_*                the shared port: avail in, one rd or wr request out
//     fwd_*                   store-to-load forwarding result (optional)
//
//   Optional feature: define DCARB_STB_FWD_EN to forward store data to a
//   conflicting load in NORMAL state instead of holding the load.
module dcache_port_arbiter #(
  parameter int STB_DEPTH  = 8,
  parameter int STB_BITS   = 3,
  parameter int HI_WM      = 6,
  parameter int LO_WM      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsq_ld_req,
  input  logic [63:0]         lsq_ld_addr,
  input  logic [6:0]          lsq_ld_pr_idx,
  input  logic [4:0]          lsq_ld_ar_idx,
  output logic                ld_accept,
  input  logic                rob_st_valid,
  input  logic [63:0]         rob_st_addr,
  input  logic [63:0]         rob_st_value,
  output logic                st_buf_full,
  output logic [STB_BITS:0]   st_buf_count,
  input  logic                flush_req,
  output logic                flush_done,
  input  logic                Dcache_avail,
  output logic                Dcache_rd_mem,
  output logic                Dcache_wr_mem,
  output logic [63:0]         Dcache_addr,
  output logic [63:0]         Dcache_st_value,
  output logic [6:0]          Dcache_pr_idx,
  output logic [4:0]          Dcache_ar_idx
`ifdef DCARB_STB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [6:0]          fwd_pr_idx,
  output logic [4:0]          fwd_ar_idx,
  output logic [63:0]         fwd_value
`endif
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DRAIN  = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t              state;
  logic [63:0]         stb_addr  [STB_DEPTH];
  logic [63:0]         stb_value [STB_DEPTH];
  logic [STB_BITS-1:0] head;
  logic [STB_BITS-1:0] tail;
  logic [STB_BITS:0]   count;
  logic [STB_BITS:0]   count_next;
  logic [SC_W-1:0]     starve_cnt;
  logic                flush_done_q;

  logic conflict;
  logic load_ok;
  logic issue_ld;
  logic issue_st;
  logic enq;
  logic fwd_hit;

`ifdef DCARB_STB_FWD_EN
  logic [STB_BITS-1:0] youngest;
`endif

  // Scan the buffer oldest-to-youngest; a load conflicts with any held store to
  // the same 8-byte word. The last match seen is the youngest one, which is the
  // entry whose data a forwarded load must return.
  always_comb begin : conflict_scan
    logic [STB_BITS-1:0] slot;
    conflict = 1'b0;
    slot     = '0;
`ifdef DCARB_STB_FWD_EN
    youngest = '0;
`endif
    for (int k = 0; k < STB_DEPTH; k++) begin
      slot = head + STB_BITS'(k);
      if (((STB_BITS+1)'(k) < count) && (stb_addr[slot][63:3] == lsq_ld_addr[63:3])) begin
        conflict = 1'b1;
`ifdef DCARB_STB_FWD_EN
        youngest = slot;
`endif
      end
    end
  end

  // Port arbitration. Loads are only eligible in NORMAL, never during a flush
  // request, and only while the oldest store has not been starved too long.
  // Everything is gated by reset so the outputs stay low while reset is held
  // even though the inputs may be toggling.
  always_comb begin
    load_ok  = reset && (state == NORMAL) && !flush_req && lsq_ld_req && !conflict &&
               (starve_cnt < SC_W'(STARVE_MAX));
    issue_ld = load_ok && Dcache_avail;
    issue_st = reset && Dcache_avail && (count != '0) && !issue_ld;
`ifdef DCARB_STB_FWD_EN
    fwd_hit  = reset && (state == NORMAL) && !flush_req && lsq_ld_req && conflict &&
               (stb_addr[youngest][2:0] == lsq_ld_addr[2:0]);
`else
    fwd_hit  = 1'b0;
`endif
    // A full buffer can still take a store in the cycle its head drains.
    enq        = rob_st_valid && (!st_buf_full || issue_st);
    count_next = count + {{STB_BITS{1'b0}}, enq} - {{STB_BITS{1'b0}}, issue_st};
  end

  always_comb begin
    ld_accept       = issue_ld || fwd_hit;
    Dcache_rd_mem   = issue_ld;
    Dcache_wr_mem   = issue_st;
    Dcache_addr     = 64'd0;
    Dcache_st_value = 64'd0;
    Dcache_pr_idx   = 7'd0;
    Dcache_ar_idx   = 5'd0;
    if (issue_ld) begin
      Dcache_addr   = lsq_ld_addr;
      Dcache_pr_idx = lsq_ld_pr_idx;
      Dcache_ar_idx = lsq_ld_ar_idx;
    end else if (issue_st) begin
      Dcache_addr     = stb_addr[head];
      Dcache_st_value = stb_value[head];
    end
  end

`ifdef DCARB_STB_FWD_EN
  always_comb begin
    fwd_valid  = fwd_hit;
    fwd_pr_idx = fwd_hit ? lsq_ld_pr_idx : 7'd0;
    fwd_ar_idx = fwd_hit ? lsq_ld_ar_idx : 5'd0;
    fwd_value  = fwd_hit ? stb_value[youngest] : 64'd0;
  end
`endif

  assign st_buf_full  = (count == (STB_BITS+1)'(STB_DEPTH));
  assign st_buf_count = count;
  assign flush_done   = flush_done_q;

  // Store data storage has no reset; only entries covered by count are ever read.
  always_ff @(posedge clock) begin
    if (enq) begin
      stb_addr[tail]  <= rob_st_addr;
      stb_value[tail] <= rob_st_value;
    end
  end

  // Pointers, occupancy, starvation counter and the NORMAL/DRAIN/FLUSH machine.
  // Mode changes look at the post-update count so the machine and the buffer
  // agree on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      starve_cnt   <= '0;
      state        <= NORMAL;
      flush_done_q <= 1'b0;
    end else begin
      if (enq)      tail <= tail + 1'b1;
      if (issue_st) head <= head + 1'b1;
      count <= count_next;

      if (issue_st || (count == '0))
        starve_cnt <= '0;
      else if (starve_cnt < SC_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;

      flush_done_q <= 1'b0;
      case (state)
        NORMAL: begin
          if (flush_req)
            state <= FLUSH;
          else if (count_next >= (STB_BITS+1)'(HI_WM))
            state <= DRAIN;
        end
        DRAIN: begin
          if (flush_req)
            state <= FLUSH;
          else if (count_next <= (STB_BITS+1)'(LO_WM))
            state <= NORMAL;
        end
        FLUSH: begin
          if (count_next == '0) begin
            flush_done_q <= 1'b1;
            state        <= NORMAL;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  // The rob must not present a store while the buffer is full and not draining.
  assert property (@(posedge clock) disable iff (!reset)
                   !(rob_st_valid && st_buf_full && !issue_st));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//   Directed self-checking bench for dcache_port_arbiter: reset behaviour,
//   load priority with starvation limit, watermark drain, full buffer,
//   flush sequence and conflicting-load handling (hold or forward).
module tb_dcache_port_arbiter;

  logic        clock;
  logic        reset;
  logic        lsq_ld_req;
  logic [63:0] lsq_ld_addr;
  logic [6:0]  lsq_ld_pr_idx;
  logic [4:0]  lsq_ld_ar_idx;
  logic        ld_accept;
  logic        rob_st_valid;
  logic [63:0] rob_st_addr;
  logic [63:0] rob_st_value;
  logic        st_buf_full;
  logic [3:0]  st_buf_count;
  logic        flush_req;
  logic        flush_done;
  logic        Dcache_avail;
  logic        Dcache_rd_mem;
  logic        Dcache_wr_mem;
  logic [63:0] Dcache_addr;
  logic [63:0] Dcache_st_value;
  logic [6:0]  Dcache_pr_idx;
  logic [4:0]  Dcache_ar_idx;
`ifdef DCARB_STB_FWD_EN
  logic        fwd_valid;
  logic [6:0]  fwd_pr_idx;
  logic [4:0]  fwd_ar_idx;
  logic [63:0] fwd_value;
`endif

  int errorCount = 0;
  int checkCount = 0;

  dcache_port_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .lsq_ld_req      (lsq_ld_req),
    .lsq_ld_addr     (lsq_ld_addr),
    .lsq_ld_pr_idx   (lsq_ld_pr_idx),
    .lsq_ld_ar_idx   (lsq_ld_ar_idx),
    .ld_accept       (ld_accept),
    .rob_st_valid    (rob_st_valid),
    .rob_st_addr     (rob_st_addr),
    .rob_st_value    (rob_st_value),
    .st_buf_full     (st_buf_full),
    .st_buf_count    (st_buf_count),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .Dcache_avail    (Dcache_avail),
    .Dcache_rd_mem   (Dcache_rd_mem),
    .Dcache_wr_mem   (Dcache_wr_mem),
    .Dcache_addr     (Dcache_addr),
    .Dcache_st_value (Dcache_st_value),
    .Dcache_pr_idx   (Dcache_pr_idx),
    .Dcache_ar_idx   (Dcache_ar_idx)
`ifdef DCARB_STB_FWD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_pr_idx      (fwd_pr_idx),
    .fwd_ar_idx      (fwd_ar_idx),
    .fwd_value       (fwd_value)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ldReq, input logic [63:0] ldAddr,
                               input logic stValid, input logic [63:0] stAddr,
                               input logic [63:0] stValue, input logic flush,
                               input logic avail);
    lsq_ld_req   = ldReq;
    lsq_ld_addr  = ldAddr;
    rob_st_valid = stValid;
    rob_st_addr  = stAddr;
    rob_st_value = stValue;
    flush_req    = flush;
    Dcache_avail = avail;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int wrSeen;
    int ldSeen;
    lsq_ld_pr_idx = 7'h11;
    lsq_ld_ar_idx = 5'h03;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset held with every input driven high: all outputs must stay low.
    applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    lsq_ld_pr_idx = 7'h7F;
    lsq_ld_ar_idx = 5'h1F;
    tick();
    #2;
    checkOutput("rst_ld_accept", {63'd0, ld_accept}, 64'd0);
    checkOutput("rst_rd", {63'd0, Dcache_rd_mem}, 64'd0);
    checkOutput("rst_wr", {63'd0, Dcache_wr_mem}, 64'd0);
    checkOutput("rst_addr", Dcache_addr, 64'd0);
    checkOutput("rst_st_value", Dcache_st_value, 64'd0);
    checkOutput("rst_pr_idx", {57'd0, Dcache_pr_idx}, 64'd0);
    checkOutput("rst_ar_idx", {59'd0, Dcache_ar_idx}, 64'd0);
    checkOutput("rst_count", {60'd0, st_buf_count}, 64'd0);
    checkOutput("rst_full", {63'd0, st_buf_full}, 64'd0);
    checkOutput("rst_flush_done", {63'd0, flush_done}, 64'd0);
    lsq_ld_pr_idx = 7'h11;
    lsq_ld_ar_idx = 5'h03;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    tick();
    checkOutput("post_rst_count", {60'd0, st_buf_count}, 64'd0);
    // NORMAL with an empty buffer grants a load straight away.
    applyStimulus(1, 64'h40, 0, 0, 0, 0, 1);
    #2;
    checkOutput("idle_ld_accept", {63'd0, ld_accept}, 64'd1);
    checkOutput("idle_rd", {63'd0, Dcache_rd_mem}, 64'd1);
    checkOutput("idle_addr", Dcache_addr, 64'h40);
    checkOutput("idle_pr_idx", {57'd0, Dcache_pr_idx}, 64'h11);
    checkOutput("idle_ar_idx", {59'd0, Dcache_ar_idx}, 64'h03);
    // Port not available: nothing issued.
    applyStimulus(1, 64'h40, 0, 0, 0, 0, 0);
    #2;
    checkOutput("noavail_ld_accept", {63'd0, ld_accept}, 64'd0);
    checkOutput("noavail_rd", {63'd0, Dcache_rd_mem}, 64'd0);

    // Starvation: loads win four cycles, the store is forced on the fifth.
    doReset();
    applyStimulus(0, 0, 1, 64'h100, 64'h55, 0, 0);
    tick();
    checkOutput("starve_count1", {60'd0, st_buf_count}, 64'd1);
    applyStimulus(1, 64'h200, 0, 0, 0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      #2;
      checkOutput($sformatf("starve_rd_c%0d", c), {63'd0, Dcache_rd_mem}, (c < 4) ? 64'd1 : 64'd0);
      checkOutput($sformatf("starve_wr_c%0d", c), {63'd0, Dcache_wr_mem}, (c < 4) ? 64'd0 : 64'd1);
      checkOutput($sformatf("starve_addr_c%0d", c), Dcache_addr, (c < 4) ? 64'h200 : 64'h100);
      tick();
    end
    checkOutput("starve_count0", {60'd0, st_buf_count}, 64'd0);

    // Watermark drain: six stores push into DRAIN; four drain, loads refused.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 64'h1000 + 64'(i * 8), 64'(i), 0, 0);
      tick();
    end
    checkOutput("drain_count6", {60'd0, st_buf_count}, 64'd6);
    applyStimulus(1, 64'h9000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #2;
      checkOutput($sformatf("drain_wr_%0d", i), {63'd0, Dcache_wr_mem}, 64'd1);
      checkOutput($sformatf("drain_ld_refused_%0d", i), {63'd0, ld_accept}, 64'd0);
      checkOutput($sformatf("drain_addr_%0d", i), Dcache_addr, 64'h1000 + 64'(i * 8));
      tick();
    end
    checkOutput("drain_count2", {60'd0, st_buf_count}, 64'd2);
    #2;
    checkOutput("drain_back_normal_ld", {63'd0, ld_accept}, 64'd1);
    checkOutput("drain_back_normal_addr", Dcache_addr, 64'h9000);

    // Full buffer; a same-cycle dequeue and enqueue keeps the count at eight.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 64'h2000 + 64'(i * 8), 64'(i), 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("full_flag", {63'd0, st_buf_full}, 64'd1);
    checkOutput("full_count8", {60'd0, st_buf_count}, 64'd8);
    applyStimulus(0, 0, 1, 64'h3000, 64'h77, 0, 1);
    #2;
    checkOutput("full_deq_wr", {63'd0, Dcache_wr_mem}, 64'd1);
    checkOutput("full_deq_addr", Dcache_addr, 64'h2000);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("full_enqdeq_count8", {60'd0, st_buf_count}, 64'd8);
    checkOutput("full_enqdeq_flag", {63'd0, st_buf_full}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("full_next_addr", Dcache_addr, 64'h2008);
    checkOutput("full_next_value", Dcache_st_value, 64'd1);

    // Flush: three stores drain, loads blocked, flush_done pulses once.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 64'h4000 + 64'(i * 8), 64'h40 + 64'(i), 0, 0);
      tick();
    end
    wrSeen = 0;
    ldSeen = 0;
    applyStimulus(1, 64'h9100, 0, 0, 0, 1, 1);
    for (int c = 0; c < 3; c++) begin
      #2;
      if (Dcache_wr_mem) wrSeen++;
      if (ld_accept) ldSeen++;
      checkOutput($sformatf("flush_done_early_%0d", c), {63'd0, flush_done}, 64'd0);
      tick();
      applyStimulus(1, 64'h9100, 0, 0, 0, 0, 1);
    end
    checkOutput("flush_wr_total", 64'(wrSeen), 64'd3);
    checkOutput("flush_ld_blocked", 64'(ldSeen), 64'd0);
    #2;
    checkOutput("flush_done_pulse", {63'd0, flush_done}, 64'd1);
    checkOutput("flush_empty", {60'd0, st_buf_count}, 64'd0);
    checkOutput("flush_ld_resumes", {63'd0, ld_accept}, 64'd1);
    tick();
    #2;
    checkOutput("flush_done_clear", {63'd0, flush_done}, 64'd0);

    // Conflicting load against a held store to 0x108.
    doReset();
    applyStimulus(0, 0, 1, 64'h108, 64'hDEAD, 0, 0);
    tick();
    applyStimulus(1, 64'h108, 0, 0, 0, 0, 0);
    #2;
`ifdef DCARB_STB_FWD_EN
    checkOutput("fwd_valid", {63'd0, fwd_valid}, 64'd1);
    checkOutput("fwd_value", fwd_value, 64'hDEAD);
    checkOutput("fwd_pr_idx", {57'd0, fwd_pr_idx}, 64'h11);
    checkOutput("fwd_ld_accept", {63'd0, ld_accept}, 64'd1);
    checkOutput("fwd_no_rd", {63'd0, Dcache_rd_mem}, 64'd0);
    applyStimulus(1, 64'h108, 0, 0, 0, 0, 1);
    #2;
    checkOutput("fwd_store_same_cycle", {63'd0, Dcache_wr_mem}, 64'd1);
    checkOutput("fwd_ld_accept_avail", {63'd0, ld_accept}, 64'd1);
`else
    checkOutput("hold_ld_accept", {63'd0, ld_accept}, 64'd0);
    tick();
    applyStimulus(1, 64'h108, 0, 0, 0, 0, 1);
    #2;
    checkOutput("hold_ld_accept_avail", {63'd0, ld_accept}, 64'd0);
    checkOutput("hold_store_wr", {63'd0, Dcache_wr_mem}, 64'd1);
    checkOutput("hold_store_addr", Dcache_addr, 64'h108);
    checkOutput("hold_store_value", Dcache_st_value, 64'hDEAD);
    checkOutput("hold_store_pr_zero", {57'd0, Dcache_pr_idx}, 64'd0);
    tick();
    #2;
    checkOutput("hold_load_rd", {63'd0, Dcache_rd_mem}, 64'd1);
    checkOutput("hold_load_accept", {63'd0, ld_accept}, 64'd1);
    checkOutput("hold_load_addr", Dcache_addr, 64'h108);
    checkOutput("hold_load_value_zero", Dcache_st_value, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
